// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Purpose : shared direction encoding for the snake game input path.
//           One-hot directions use the keys_n bit mapping:
//           bit3 up, bit2 down, bit1 left, bit0 right.
// Contents: dir_t, DIR_* constants, DIR_RESET, dir_evt_t event payload,
//           key_state_t debouncer states, opposite_dir() helper.
// ---------------------------------------------------------------------------
package snake_pkg;

   typedef logic [3:0] dir_t;

   localparam dir_t DIR_UP    = 4'b1000;
   localparam dir_t DIR_DOWN  = 4'b0100;
   localparam dir_t DIR_LEFT  = 4'b0010;
   localparam dir_t DIR_RIGHT = 4'b0001;
   localparam dir_t DIR_RESET = DIR_RIGHT;

   // A collapsed press event from the four debouncers
   typedef struct packed {
      logic valid;
      dir_t dir;
   } dir_evt_t;

   // UNARMED: after reset, waits for a stable release before any press counts
   typedef enum logic [1:0] {
      KEY_UNARMED  = 2'd0,
      KEY_RELEASED = 2'd1,
      KEY_PRESSED  = 2'd2
   } key_state_t;

   // Opposite direction; a non-one-hot input maps to zero so it never matches
   function automatic dir_t opposite_dir(input dir_t d);
      dir_t r;
      case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_RIGHT: r = DIR_LEFT;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dir_input_queue_if.sv
// ---------------------------------------------------------------------------
// dir_input_queue_if
// Purpose : bundles the key inputs, game tick and direction outputs of
//           dir_input_queue.
// Signals : keys_n[3:0]  raw active-low pushbuttons (up,down,left,right)
//           tick         one-cycle game-step pulse
//           dir[3:0]     current one-hot direction
//           dir_changed  pulse after dir takes a new value
//           pending      number of queued turns
//           dropped      pulse when a press event is discarded
// Modports: master (drives keys/tick), slave (the queue block)
// ---------------------------------------------------------------------------
interface dir_input_queue_if
   import snake_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4
);
   localparam int unsigned PEND_W = $clog2(QUEUE_DEPTH + 1);

   logic [3:0]        keys_n;
   logic              tick;
   dir_t              dir;
   logic              dir_changed;
   logic [PEND_W-1:0] pending;
   logic              dropped;

   modport master (
      output keys_n, tick,
      input  dir, dir_changed, pending, dropped
   );

   modport slave (
      input  keys_n, tick,
      output dir, dir_changed, pending, dropped
   );

endinterface

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Purpose : one pushbutton: 2-flop synchronizer, inversion, debounce counter
//           and press-edge detection.
// Ports   : clk, rst        clock, async active-high reset
//           i_key_n         raw active-low key
//           o_press         one-cycle pulse on an accepted release->press
// A key held through reset is ignored until it has been seen released for
// DEBOUNCE_CYCLES samples. The synchronizer resets to "released" and can
// contribute at most two released samples, so DEBOUNCE_CYCLES must be >= 3.
// ---------------------------------------------------------------------------
module key_debounce
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_press
);
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   key_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   logic             w_sample;
   key_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_press_nxt;

   // Synchronizer, reset to the released level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = ~r_sync2;

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= KEY_UNARMED;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_press <= w_press_nxt;
      end
   end

   // Counter runs while the sample differs from the accepted level, clears otherwise
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_press_nxt = 1'b0;
      case (r_state)
         KEY_UNARMED: begin
            if (!w_sample) begin
               if (r_cnt == CNT_MAX) w_state_nxt = KEY_RELEASED;
               else                  w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
            end
         end
         KEY_RELEASED: begin
            if (w_sample) begin
               if (r_cnt == CNT_MAX) begin
                  w_state_nxt = KEY_PRESSED;
                  w_press_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
               end
            end
         end
         KEY_PRESSED: begin
            if (!w_sample) begin
               if (r_cnt == CNT_MAX) w_state_nxt = KEY_RELEASED;
               else                  w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
            end
         end
         default: w_state_nxt = KEY_UNARMED;
      endcase
   end

   assign o_press = r_press;

endmodule

// File: rtl/dir_input_queue.sv
// ---------------------------------------------------------------------------
// dir_input_queue
// Purpose : debounces four direction keys, collapses simultaneous presses
//           (up > down > left > right), queues accepted turns and applies
//           the oldest one to dir on each game tick.
// Ports   : clk, rst  clock, async active-high reset
//           bus       dir_input_queue_if.slave (keys_n, tick, dir,
//                     dir_changed, pending, dropped)
// Params  : DEBOUNCE_CYCLES (>= 3), QUEUE_DEPTH (power of two, 2..16)
// Config  : DIR_REVERSE_BLOCK_EN defined -> presses opposite to the newest
//           reference direction are dropped as well.
// ---------------------------------------------------------------------------
module dir_input_queue
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned QUEUE_DEPTH     = 4
) (
   input logic              clk,
   input logic              rst,
   dir_input_queue_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int unsigned PEND_W = $clog2(QUEUE_DEPTH + 1);

   logic [3:0]        w_press;
   dir_evt_t          w_evt;
   dir_t              w_ref;
   logic              w_full;
   logic              w_pop;
   logic              w_reject;
   logic              w_push;
   logic              w_drop;

   dir_t              r_mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PEND_W-1:0] r_count;
   dir_t              r_dir;
   logic              r_dir_changed;
   logic              r_dropped;

   // One debouncer per key
   for (genvar g = 0; g < 4; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key (
         .clk     (clk),
         .rst     (rst),
         .i_key_n (bus.keys_n[g]),
         .o_press (w_press[g])
      );
   end

   // Priority collapse of simultaneous presses
   always_comb begin
      w_evt = '0;
      if (w_press[3]) begin
         w_evt.valid = 1'b1;
         w_evt.dir   = DIR_UP;
      end else if (w_press[2]) begin
         w_evt.valid = 1'b1;
         w_evt.dir   = DIR_DOWN;
      end else if (w_press[1]) begin
         w_evt.valid = 1'b1;
         w_evt.dir   = DIR_LEFT;
      end else if (w_press[0]) begin
         w_evt.valid = 1'b1;
         w_evt.dir   = DIR_RIGHT;
      end
   end

   // Compare against the newest queued turn, or dir when nothing is queued
   assign w_ref  = (r_count != '0) ? r_mem[PTR_W'(r_wr_ptr - 1'b1)] : r_dir;
   assign w_full = (r_count == PEND_W'(QUEUE_DEPTH));
   // Pop only what was queued before this edge, so a same-cycle push waits a tick
   assign w_pop  = bus.tick && (r_count != '0);

`ifdef DIR_REVERSE_BLOCK_EN
   assign w_reject = (w_evt.dir == w_ref) || (w_full && !bus.tick) ||
                     (w_evt.dir == opposite_dir(w_ref));
`else
   assign w_reject = (w_evt.dir == w_ref) || (w_full && !bus.tick);
`endif

   assign w_push = w_evt.valid && !w_reject;
   assign w_drop = w_evt.valid &&  w_reject;

   // Turn FIFO and applied direction; a full queue with tick swaps one slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(QUEUE_DEPTH); i++) r_mem[i] <= DIR_RESET;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_dir         <= DIR_RESET;
         r_dir_changed <= 1'b0;
         r_dropped     <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_evt.dir;
            r_wr_ptr        <= PTR_W'(r_wr_ptr + 1'b1);
         end
         if (w_pop) begin
            r_dir    <= r_mem[r_rd_ptr];
            r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= PEND_W'(r_count + 1'b1);
            2'b01:   r_count <= PEND_W'(r_count - 1'b1);
            default: r_count <= r_count;
         endcase
         r_dir_changed <= w_pop;
         r_dropped     <= w_drop;
      end
   end

   assign bus.dir         = r_dir;
   assign bus.dir_changed = r_dir_changed;
   assign bus.pending     = r_count;
   assign bus.dropped     = r_dropped;

endmodule

// File: doc/dir_input_queue.md
DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable samples before a key level is accepted.
REQ-002 Parameter QUEUE_DEPTH, default 4: pending-turn FIFO depth, power of two, 2..16.
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 keys_n  input  4  raw pushbuttons, active-low, asynchronous; bit3 up, bit2 down, bit1 left, bit0 right.
REQ-006 tick  input  1  one-cycle game-step pulse from the game rate divider.
REQ-007 dir  output  4  current one-hot direction, same bit mapping as keys_n; feeds the snake logic dirIn port.
REQ-008 dir_changed  output  1  one-cycle pulse in the cycle after dir takes a new value.
REQ-009 pending  output  clog2(QUEUE_DEPTH+1)  number of queued turns.
REQ-010 dropped  output  1  one-cycle pulse when a press event is discarded.

Function
REQ-011 Each keys_n bit SHALL pass through a 2-flop synchronizer, then be inverted.
REQ-012 Each debounced level SHALL change only after DEBOUNCE_CYCLES consecutive identical synchronized samples that differ from the current level; the per-key counter SHALL clear on any mismatch.
REQ-013 A press event SHALL be a debounced 0->1 transition, valid one cycle; a release SHALL generate no event.
REQ-014 Simultaneous press events SHALL collapse to one event with priority up > down > left > right.
REQ-015 Reference direction = newest queued entry if pending>0, else dir.
REQ-016 An event equal to the reference direction SHALL be discarded with dropped=1.
REQ-017 An event arriving while pending==QUEUE_DEPTH and tick==0 SHALL be discarded with dropped=1.
REQ-018 Otherwise the event SHALL be pushed; pending increments the next cycle.
REQ-019 On tick with pending>0, the oldest entry SHALL be popped into dir in the same edge; dir_changed SHALL pulse the following cycle.
REQ-020 On tick with pending==0, dir SHALL hold and dir_changed SHALL stay 0.
REQ-021 Simultaneous push and pop SHALL both occur; pending is unchanged; a full queue accepts the push in that cycle.
REQ-022 An event pushed into an empty queue in the same cycle as tick SHALL NOT be applied by that tick; it is applied by the next tick.
REQ-023 Read and write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-024 dir SHALL always be exactly one-hot.
REQ-025 Latency from a clean raw press edge to the queue push SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-026 On rst: dir=4'b0001 (right), pending=0, pointers=0, dir_changed=0, dropped=0, synchronizers=released (1), debounced levels=0, counters=0.
REQ-027 A reset asserted mid-debounce or while turns are queued SHALL discard all state; no event SHALL fire on deassertion while keys are held, until the key is released and pressed again.

Configuration
REQ-028 Macro DIR_REVERSE_BLOCK_EN defined: an event opposite to the reference direction (up/down, left/right) SHALL be discarded with dropped=1.
REQ-029 Macro undefined: opposite-direction events SHALL be queued normally; only REQ-016 and REQ-017 drop events.

Structure
REQ-030 Shared package snake_pkg SHALL hold the direction one-hot constants DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, the reset direction, and an opposite-direction function.
REQ-031 Sub-module key_debounce (synchronizer + counter + edge detect, one key) SHALL be instantiated 4 times.

Verification (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4)
REQ-032 Reset, no keys, 3 ticks -> dir=0001, pending=0, dir_changed never 1.
REQ-033 Up bounce: pressed for 2 cycles, released for 1, then held -> exactly one push 7 cycles after the final edge; next tick -> dir=1000, dir_changed pulses once.
REQ-034 Presses down, left, up, right, up with no tick -> the fifth press is dropped at pending=4; 4 ticks -> dir sequence 0100, 0010, 1000, 0001.
REQ-035 dir=0001, press right -> dropped=1, pending=0.
REQ-036 dir=0001, press left -> with DIR_REVERSE_BLOCK_EN: dropped; without it: queued, and the next tick sets dir=0010.
REQ-037 Two turns queued, assert rst for 1 cycle mid-debounce -> dir=0001, pending=0, no event while the key stays held.
